// File: rtl/mem_ctrl.sv
// Purpose : single-outstanding request controller in front of the word-addressed data RAM.
// Latency : in-range MIN_WAIT+2 cycles minimum (accept to resp_valid), out-of-range 1 cycle.
// Backpr. : req_ready is high only in IDLE, so one request is in flight and nothing is queued.
// Option  : `define MEM_CTRL_WRITE_VERIFY_EN re-reads every successful write and flags a mismatch.
module mem_ctrl #(
    parameter int DEPTH    = 32,
    parameter int MIN_WAIT = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_data,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    input  logic        mem_response,
    input  logic [31:0] mem_out
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SETTLE     = 3'd1;
    localparam logic [2:0] S_WAIT       = 3'd2;
    localparam logic [2:0] S_DONE       = 3'd3;
`ifdef MEM_CTRL_WRITE_VERIFY_EN
    localparam logic [2:0] S_VRD_SETTLE = 3'd4;
    localparam logic [2:0] S_VRD_WAIT   = 3'd5;
`endif

    // Counter preloads; a count of N means N+1 cycles spent in the state.
    localparam logic [7:0]  SETTLE_CNT = 8'(MIN_WAIT - 1);
    localparam logic [7:0]  WAIT_CNT   = 8'(TIMEOUT - 1);
    localparam logic [31:0] DEPTH_W    = 32'(DEPTH);

    logic [2:0] state;
    logic [7:0] cnt;

    assign req_ready = (state == S_IDLE);

    // Main FSM: issue to the RAM, hold off for the settle window, then wait for
    // the level response (or give up) and publish the result for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_data   <= 32'd0;
            mem_addr   <= 32'd0;
            mem_wr     <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_addr >= DEPTH_W) begin
                            // Rejected without touching the RAM interface.
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                            resp_valid <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            mem_addr <= req_addr;
                            if (req_wr) begin
                                mem_data <= req_wdata;
                            end
                            mem_wr <= req_wr;
                            cnt    <= SETTLE_CNT;
                            state  <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    // A stale high response from an identical previous access
                    // must not complete the request early.
                    if (cnt == 8'd0) begin
                        cnt   <= WAIT_CNT;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_WAIT: begin
                    if (mem_response) begin
`ifdef MEM_CTRL_WRITE_VERIFY_EN
                        if (mem_wr) begin
                            mem_wr <= 1'b0;
                            cnt    <= SETTLE_CNT;
                            state  <= S_VRD_SETTLE;
                        end else begin
                            resp_rdata <= mem_out;
                            resp_err   <= 1'b0;
                            resp_valid <= 1'b1;
                            state      <= S_DONE;
                        end
`else
                        resp_rdata <= mem_wr ? 32'd0 : mem_out;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= S_DONE;
`endif
                    end else if (cnt == 8'd0) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'd0;
                        resp_valid <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
`ifdef MEM_CTRL_WRITE_VERIFY_EN
                S_VRD_SETTLE: begin
                    if (cnt == 8'd0) begin
                        cnt   <= WAIT_CNT;
                        state <= S_VRD_WAIT;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_VRD_WAIT: begin
                    // Read-back compares against the data just written.
                    if (mem_response) begin
                        resp_err   <= (mem_out != mem_data);
                        resp_rdata <= 32'd0;
                        resp_valid <= 1'b1;
                        state      <= S_DONE;
                    end else if (cnt == 8'd0) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'd0;
                        resp_valid <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
`endif
                S_DONE: begin
                    mem_wr <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
